mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one unified memory port between the core's instruction-fetch request channel and its data-memory load/store channel.
- Sits between the core and the single-port memory. Each side uses the codebase request/we_re/mask/valid handshake.
- Forwards one transaction at a time. Round-robin when both sides contend. Returns read data and a one-cycle valid pulse to the winner.

Parameters:
- ADDR_WIDTH, 32, address width on all channels.
- DATA_WIDTH, 32, read/write data width.
- MASK_WIDTH, 4, byte-enable width (DATA_WIDTH/8).
- TIMEOUT_CYCLES, 64, wait-state limit; used only with MEM_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- im_request  in  1  instruction-side request (level).
- im_we_re  in  1  1=write, 0=read.
- im_mask  in  MASK_WIDTH  byte enables.
- im_addr  in  ADDR_WIDTH  instruction address.
- im_rdata  out  DATA_WIDTH  read data.
- im_valid  out  1  completion pulse.
- dm_request  in  1  data-side request (level).
- dm_we_re  in  1  1=store, 0=load.
- dm_mask  in  MASK_WIDTH  byte enables.
- dm_addr  in  ADDR_WIDTH  data address.
- dm_wdata  in  DATA_WIDTH  store data.
- dm_rdata  out  DATA_WIDTH  load data.
- dm_valid  out  1  completion pulse.
- mem_request  out  1  memory request.
- mem_we_re  out  1  memory write enable.
- mem_mask  out  MASK_WIDTH  memory byte enables.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data.
- mem_valid  in  1  memory completion.
- busy  out  1  transaction in flight (state != IDLE).
- err  out  1  timeout-abort pulse, coincident with the returned valid.

Behaviour:
- Reset (rst=0, async): state=IDLE, last_grant=IM, all outputs and registers 0. Reset mid-transaction drops mem_request immediately. No valid is returned for the aborted transaction.
- State IDLE: sample requests each edge.
  - Only one side requesting: grant it.
  - Both requesting: grant the side not in last_grant, so DM wins first after reset.
  - On grant: register the winner's we_re/mask/addr/wdata into the mem_* output registers; for IM, mem_wdata=0.
  - Update last_grant, go to WAIT_IM or WAIT_DM.
- Latency: mem_request rises the cycle after the request is sampled (1-cycle registered grant).
- State WAIT_IM/WAIT_DM: hold mem_request and all mem_* fields stable.
  - On mem_valid=1: capture mem_rdata into rdata_q, clear mem_request at that edge, go to RESP.
  - A requester dropping its request while its transaction is in WAIT is ignored. The transaction completes and valid is still pulsed.
- State RESP: exactly one of im_valid/dm_valid=1 for one cycle, for the granted side; then go to IDLE.
  - im_rdata and dm_rdata both drive rdata_q; a write returns rdata_q=mem_rdata as sampled.
  - A requester holding request high past its valid cycle starts a new transaction. Back-to-back transactions cost 3 cycles of overhead plus memory latency.
- mem_valid outside WAIT: ignored.
- busy=1 in WAIT_* and RESP.
- Requests are never lost: a losing side stays pending and wins the next IDLE arbitration.

Optional Feature:
- MEM_ARB_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT_* and increments each WAIT cycle.
  - Upon reaching TIMEOUT_CYCLES-1 without mem_valid: drop mem_request, set rdata_q=0, go to RESP. The valid pulse carries err=1.
  - mem_valid in the same cycle as expiry takes precedence: normal completion, err=0.
- Not defined: no counter; WAIT lasts indefinitely; err tied to 0.

Decomposition:
- Package mem_arb_pkg holds:
  - arb_state_t enum: IDLE, WAIT_IM, WAIT_DM, RESP.
  - grant_t enum: GRANT_IM, GRANT_DM.
  - Default width localparams.
- One sub-module, mem_arb_timer: loadable wait counter with an expire output. Instantiated only under MEM_ARB_TIMEOUT_EN.

Test Plan:
- IM-only read: im_addr=0x100, memory returns 0xDEADBEEF after 2 wait cycles -> mem_request high one cycle after request, mem_addr=0x100, im_valid pulse with im_rdata=0xDEADBEEF; dm_valid stays 0.
- Simultaneous requests after reset: IM read 0x0, DM store 0x2000/0x12345678 mask 0xF -> DM served first (mem_we_re=1, mem_wdata=0x12345678), then IM; the two valid pulses never overlap.
- Sustained contention, both requests held high for 6 transactions -> grants alternate DM,IM,DM,IM,DM,IM.
- Request withdrawn during WAIT_DM with mem_valid 3 cycles later -> dm_valid still pulses once; no new transaction starts.
- Async reset asserted in WAIT_IM -> mem_request and busy go 0 immediately with no clock edge; no im_valid after release.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, memory never responds -> after 8 WAIT cycles, im_valid=1 and err=1 with im_rdata=0; the next request is arbitrated normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IM = 2'd1,
        WAIT_DM = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_IM = 1'b0,
        GRANT_DM = 1'b1
    } grant_t;

    localparam int unsigned DefAddrWidth     = 32;
    localparam int unsigned DefDataWidth     = 32;
    localparam int unsigned DefMaskWidth     = DefDataWidth / 8;
    localparam int unsigned DefTimeoutCycles = 64;

endpackage

// File: rtl/mem_arb_timer.sv
// Wait-state counter: held at zero while clear_i, counts while en_i, flags the last allowed cycle.
module mem_arb_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] count_q, count_d;

    assign expire_o = en_i && (count_q == Limit);

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && !expire_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction and data channels.
// Optional wait-state timeout abort enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DefAddrWidth,
    parameter int unsigned DATA_WIDTH     = DefDataWidth,
    parameter int unsigned MASK_WIDTH     = DefMaskWidth,
    parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  im_request,
    input  logic                  im_we_re,
    input  logic [MASK_WIDTH-1:0] im_mask,
    input  logic [ADDR_WIDTH-1:0] im_addr,
    output logic [DATA_WIDTH-1:0] im_rdata,
    output logic                  im_valid,
    input  logic                  dm_request,
    input  logic                  dm_we_re,
    input  logic [MASK_WIDTH-1:0] dm_mask,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_valid,
    output logic                  mem_request,
    output logic                  mem_we_re,
    output logic [MASK_WIDTH-1:0] mem_mask,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_valid,
    output logic                  busy,
    output logic                  err
);

    arb_state_t            state_q, state_d;
    grant_t                last_grant_q, last_grant_d;
    logic                  mem_request_q, mem_request_d;
    logic                  mem_we_re_q, mem_we_re_d;
    logic [MASK_WIDTH-1:0] mem_mask_q, mem_mask_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  timer_expire;

`ifdef MEM_ARB_TIMEOUT_EN
    // Clearing throughout IDLE is equivalent to clearing on entry to WAIT.
    mem_arb_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i   (clk),
        .rst_ni  (rst),
        .clear_i (state_q == IDLE),
        .en_i    ((state_q == WAIT_IM) || (state_q == WAIT_DM)),
        .expire_o(timer_expire)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timer_expire   = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        mem_request_d = mem_request_q;
        mem_we_re_d   = mem_we_re_q;
        mem_mask_d    = mem_mask_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        rdata_d       = rdata_q;
        err_d         = err_q;

        unique case (state_q)
            IDLE: begin
                err_d = 1'b0;
                // DM wins when alone or when IM was served last.
                if (dm_request && (!im_request || (last_grant_q == GRANT_IM))) begin
                    last_grant_d  = GRANT_DM;
                    mem_request_d = 1'b1;
                    mem_we_re_d   = dm_we_re;
                    mem_mask_d    = dm_mask;
                    mem_addr_d    = dm_addr;
                    mem_wdata_d   = dm_wdata;
                    state_d       = WAIT_DM;
                end else if (im_request) begin
                    last_grant_d  = GRANT_IM;
                    mem_request_d = 1'b1;
                    mem_we_re_d   = im_we_re;
                    mem_mask_d    = im_mask;
                    mem_addr_d    = im_addr;
                    mem_wdata_d   = '0;
                    state_d       = WAIT_IM;
                end
            end
            WAIT_IM, WAIT_DM: begin
                if (mem_valid) begin
                    rdata_d       = mem_rdata;
                    mem_request_d = 1'b0;
                    state_d       = RESP;
                end else if (timer_expire) begin
                    rdata_d       = '0;
                    mem_request_d = 1'b0;
                    err_d         = 1'b1;
                    state_d       = RESP;
                end
            end
            RESP: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            last_grant_q  <= GRANT_IM;
            mem_request_q <= 1'b0;
            mem_we_re_q   <= 1'b0;
            mem_mask_q    <= '0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            mem_request_q <= mem_request_d;
            mem_we_re_q   <= mem_we_re_d;
            mem_mask_q    <= mem_mask_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            rdata_q       <= rdata_d;
            err_q         <= err_d;
        end
    end

    assign mem_request = mem_request_q;
    assign mem_we_re   = mem_we_re_q;
    assign mem_mask    = mem_mask_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign im_rdata    = rdata_q;
    assign dm_rdata    = rdata_q;
    assign im_valid    = (state_q == RESP) && (last_grant_q == GRANT_IM);
    assign dm_valid    = (state_q == RESP) && (last_grant_q == GRANT_DM);
    assign busy        = (state_q != IDLE);
    assign err         = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        im_request, im_we_re;
    logic [3:0]  im_mask;
    logic [31:0] im_addr, im_rdata;
    logic        im_valid;
    logic        dm_request, dm_we_re;
    logic [3:0]  dm_mask;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        dm_valid;
    logic        mem_request, mem_we_re;
    logic [3:0]  mem_mask;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_valid, busy, err;

    int checks   = 0;
    int failures = 0;
    bit last_dm  = 1'b0;  // model: side served most recently (0 = IM)

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .MASK_WIDTH    (4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .im_request (im_request),
        .im_we_re   (im_we_re),
        .im_mask    (im_mask),
        .im_addr    (im_addr),
        .im_rdata   (im_rdata),
        .im_valid   (im_valid),
        .dm_request (dm_request),
        .dm_we_re   (dm_we_re),
        .dm_mask    (dm_mask),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_rdata   (dm_rdata),
        .dm_valid   (dm_valid),
        .mem_request(mem_request),
        .mem_we_re  (mem_we_re),
        .mem_mask   (mem_mask),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_valid  (mem_valid),
        .busy       (busy),
        .err        (err)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction from grant to valid; winner predicted from the request levels.
    task automatic run_txn(input int lat, input logic [31:0] rd, input bit drop_in_wait);
        bit          win_dm;
        logic [68:0] exp_cmd;
        int          n;
        win_dm  = (im_request && dm_request) ? !last_dm : dm_request;
        exp_cmd = win_dm ? {dm_we_re, dm_mask, dm_addr, dm_wdata}
                         : {im_we_re, im_mask, im_addr, 32'h0};
        n = 0;
        while (!mem_request && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("grant_seen", mem_request, 1'b1);
        check("mem_cmd", {mem_we_re, mem_mask, mem_addr, mem_wdata}, exp_cmd);
        if (drop_in_wait) begin
            if (win_dm) dm_request = 1'b0;
            else        im_request = 1'b0;
        end
        repeat (lat) @(negedge clk);
        check("wait_hold", {mem_request, busy, im_valid, dm_valid,
                            mem_we_re, mem_mask, mem_addr, mem_wdata}, {4'b1100, exp_cmd});
        mem_rdata = rd;
        mem_valid = 1'b1;
        @(negedge clk);
        mem_valid = 1'b0;
        mem_rdata = $urandom;
        check("valid_side", {im_valid, dm_valid}, win_dm ? 2'b01 : 2'b10);
        check("rdata", win_dm ? dm_rdata : im_rdata, rd);
        check("resp_flags", {mem_request, busy, err}, 3'b010);
        last_dm = win_dm;
    endtask

    initial begin
        bit seen;
        rst        = 1'b0;
        im_request = 1'b0; im_we_re = 1'b0; im_mask = '0; im_addr = '0;
        dm_request = 1'b0; dm_we_re = 1'b0; dm_mask = '0; dm_addr = '0; dm_wdata = '0;
        mem_rdata  = '0;   mem_valid = 1'b0;
        #23;
        check("reset_outs", {mem_request, mem_we_re, mem_mask, mem_addr, mem_wdata, im_valid,
                             dm_valid, busy, err, im_rdata, dm_rdata}, '0);
        @(negedge clk);
        rst = 1'b1;

        // Simultaneous requests right after reset: DM first, then IM.
        im_request = 1'b1; im_we_re = 1'b0; im_mask = 4'hF; im_addr = 32'h0;
        dm_request = 1'b1; dm_we_re = 1'b1; dm_mask = 4'hF;
        dm_addr = 32'h2000; dm_wdata = 32'h1234_5678;
        run_txn(1, 32'hA5A5_0001, 1'b0);
        check("first_is_dm", last_dm, 1'b1);
        dm_request = 1'b0;
        run_txn(1, 32'h0BAD_F00D, 1'b0);
        im_request = 1'b0;
        repeat (2) @(negedge clk);

        // IM-only read with registered-grant latency.
        im_request = 1'b1; im_we_re = 1'b0; im_mask = 4'hF; im_addr = 32'h100;
        check("pre_grant", mem_request, 1'b0);
        @(negedge clk);
        check("im_latency", mem_request, 1'b1);
        run_txn(2, 32'hDEAD_BEEF, 1'b0);
        im_request = 1'b0;
        repeat (2) @(negedge clk);

        // Sustained contention: grants alternate starting with DM.
        im_request = 1'b1; im_addr = 32'h400;
        dm_request = 1'b1; dm_we_re = 1'b0; dm_addr = 32'h3000;
        for (int i = 0; i < 6; i++) begin
            run_txn(i % 3, $urandom, 1'b0);
            check("rr_alternate", last_dm, (i % 2 == 0) ? 1'b1 : 1'b0);
        end
        im_request = 1'b0; dm_request = 1'b0;
        repeat (2) @(negedge clk);

        // DM withdraws during WAIT: still completes once, nothing follows.
        dm_request = 1'b1; dm_we_re = 1'b1; dm_mask = 4'h3;
        dm_addr = 32'h2040; dm_wdata = 32'hCAFE_0123;
        run_txn(3, 32'h5555_AAAA, 1'b1);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (mem_request || busy || dm_valid || im_valid) seen = 1'b1;
        end
        check("no_new_txn", seen, 1'b0);

        // Async reset during WAIT_IM.
        im_request = 1'b1; im_addr = 32'h800;
        @(negedge clk);
        check("reset_pre", {mem_request, busy}, 2'b11);
        #2 rst = 1'b0;
        #1 check("reset_async", {mem_request, busy}, 2'b00);
        im_request = 1'b0;
        @(negedge clk);
        rst     = 1'b1;
        last_dm = 1'b0;
        seen    = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (im_valid || busy) seen = 1'b1;
        end
        check("no_valid_after_rst", seen, 1'b0);

        // Randomized traffic; losers stay pending with their fields intact.
        for (int i = 0; i < 30; i++) begin
            if (!im_request && $urandom_range(1) == 1) begin
                im_request = 1'b1; im_we_re = 1'($urandom);
                im_mask = 4'($urandom); im_addr = $urandom;
            end
            if (!dm_request && $urandom_range(1) == 1) begin
                dm_request = 1'b1; dm_we_re = 1'($urandom);
                dm_mask = 4'($urandom); dm_addr = $urandom; dm_wdata = $urandom;
            end
            if (!im_request && !dm_request) begin
                im_request = 1'b1; im_addr = $urandom;
            end
            run_txn(int'($urandom_range(3)), $urandom, 1'b0);
            if (last_dm) dm_request = 1'b0;
            else         im_request = 1'b0;
        end
        while (im_request || dm_request) begin
            run_txn(1, $urandom, 1'b0);
            if (last_dm) dm_request = 1'b0;
            else         im_request = 1'b0;
        end
        repeat (2) @(negedge clk);

`ifdef MEM_ARB_TIMEOUT_EN
        // Memory never answers: abort after 8 WAIT cycles with err.
        im_request = 1'b1; im_we_re = 1'b0; im_addr = 32'h900;
        @(negedge clk);
        check("to_grant", mem_request, 1'b1);
        seen = 1'b0;
        repeat (7) begin
            @(negedge clk);
            if (im_valid || !mem_request) seen = 1'b1;
        end
        check("to_early", seen, 1'b0);
        @(negedge clk);
        check("to_resp", {im_valid, dm_valid, err, mem_request}, 4'b1010);
        check("to_rdata", im_rdata, 32'h0);
        last_dm    = 1'b0;
        im_request = 1'b0;
        dm_request = 1'b1; dm_we_re = 1'b0; dm_addr = 32'h1234;
        run_txn(2, 32'h7777_8888, 1'b0);
        dm_request = 1'b0;
        repeat (2) @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
